// File: rtl/lfsr_pkg.sv
// Shared types, constants and the LFSR step function for the LFSR frame decryptor.
package lfsr_pkg;

    localparam int unsigned LFSR_W   = 6;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned NUM_TAPS = 6;

    localparam logic [DATA_W-1:0] PRE_CHAR = 8'h5F;

    localparam logic [LFSR_W-1:0] TAP_LIST [0:NUM_TAPS-1] =
        '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        LOAD_K,
        CHECK,
        LOAD_D,
        RUN,
        PAD,
        DONE
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] taps);
        return {s[LFSR_W-2:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr6.sv
// 6-bit Fibonacci-style LFSR core: synchronous load of start, step when enabled.
module lfsr6
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              init,
    input  logic [LFSR_W-1:0] taps,
    input  logic [LFSR_W-1:0] start,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = start;
        end else if (en) begin
            state_d = lfsr_next(state_q, taps);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_decrypt.sv
// LFSR frame decryptor: recovers seed and taps from the '_' preamble, writes plaintext.
// Optional space padding of the output region is enabled with DECRYPT_PAD_EN.
module lfsr_decrypt
    import lfsr_pkg::*;
#(
    parameter int unsigned MSG_BASE  = 64,
    parameter int unsigned OUT_BASE  = 0,
    parameter int unsigned MSG_LEN   = 64,
    parameter int unsigned CHECK_LEN = 8
) (
    input  logic              clk,
    input  logic              init,
    input  logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] data_in,
    output logic              write_en,
    output logic              done,
    output logic              fail,
    output logic [2:0]        taps_sel
);

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] start_q, start_d;
    logic [2:0]        k_q, k_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] w_q, w_d;
    logic              in_pre_q, in_pre_d;
    logic              fail_q, fail_d;
    logic [2:0]        taps_sel_q, taps_sel_d;

    logic              core_en;
    logic              core_init;
    logic [LFSR_W-1:0] core_start;
    logic [LFSR_W-1:0] core_taps;
    logic [LFSR_W-1:0] lfsr;
    logic [DATA_W-1:0] plain;
    logic              match;

    lfsr6 u_lfsr (
        .clk   (clk),
        .rst   (init),
        .en    (core_en),
        .init  (core_init),
        .taps  (core_taps),
        .start (core_start),
        .state (lfsr)
    );

    assign plain = data_out ^ {2'b00, lfsr};
    assign match = (data_out == (PRE_CHAR ^ {2'b00, lfsr}));

    // Candidate search, then decryption pass; memory ports are combinational from state.
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        k_d        = k_q;
        idx_d      = idx_q;
        j_d        = j_q;
        w_d        = w_q;
        in_pre_d   = in_pre_q;
        fail_d     = fail_q;
        taps_sel_d = taps_sel_q;
        raddr      = '0;
        waddr      = '0;
        data_in    = '0;
        write_en   = 1'b0;
        done       = 1'b0;
        core_en    = 1'b0;
        core_init  = 1'b0;
        core_start = start_q;
        core_taps  = TAP_LIST[k_q];

        case (state_q)
            IDLE: state_d = SEED;
            SEED: begin
                raddr   = ADDR_W'(MSG_BASE);
                start_d = data_out[LFSR_W-1:0] ^ 6'h1F;
                k_d     = 3'd0;
                state_d = LOAD_K;
            end
            LOAD_K: begin
                // Byte 1 was scrambled with the state one step past the seed.
                core_init  = 1'b1;
                core_start = lfsr_next(start_q, TAP_LIST[k_q]);
                idx_d      = ADDR_W'(1);
                state_d    = CHECK;
            end
            CHECK: begin
                raddr = ADDR_W'(MSG_BASE) + idx_q;
                if (match) begin
                    if (idx_q == ADDR_W'(CHECK_LEN - 1)) begin
                        taps_sel_d = k_q;
                        state_d    = LOAD_D;
                    end else begin
                        core_en = 1'b1;
                        idx_d   = idx_q + ADDR_W'(1);
                    end
                end else if (k_q < 3'(NUM_TAPS - 1)) begin
                    k_d     = k_q + 3'd1;
                    state_d = LOAD_K;
                end else begin
                    fail_d  = 1'b1;
                    state_d = DONE;
                end
            end
            LOAD_D: begin
                core_init  = 1'b1;
                core_start = start_q;
                j_d        = '0;
                w_d        = '0;
                in_pre_d   = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                raddr   = ADDR_W'(MSG_BASE) + j_q;
                core_en = 1'b1;
                j_d     = j_q + ADDR_W'(1);
                // Only the leading run of '_' is stripped.
                if (!(in_pre_q && (plain == PRE_CHAR))) begin
                    in_pre_d = 1'b0;
                    write_en = 1'b1;
                    waddr    = ADDR_W'(OUT_BASE) + w_q;
                    data_in  = plain;
                    w_d      = w_q + ADDR_W'(1);
                end
                if (j_q == ADDR_W'(MSG_LEN - 1)) begin
`ifdef DECRYPT_PAD_EN
                    state_d = PAD;
`else
                    state_d = DONE;
`endif
                end
            end
            PAD: begin
`ifdef DECRYPT_PAD_EN
                if (w_q < ADDR_W'(MSG_LEN)) begin
                    write_en = 1'b1;
                    waddr    = ADDR_W'(OUT_BASE) + w_q;
                    data_in  = 8'h20;
                    w_d      = w_q + ADDR_W'(1);
                    if (w_q == ADDR_W'(MSG_LEN - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
`else
                state_d = DONE;
`endif
            end
            DONE: done = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q    <= IDLE;
            start_q    <= '0;
            k_q        <= '0;
            idx_q      <= '0;
            j_q        <= '0;
            w_q        <= '0;
            in_pre_q   <= 1'b0;
            fail_q     <= 1'b0;
            taps_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            j_q        <= j_d;
            w_q        <= w_d;
            in_pre_q   <= in_pre_d;
            fail_q     <= fail_d;
            taps_sel_q <= taps_sel_d;
        end
    end

    assign fail     = fail_q;
    assign taps_sel = taps_sel_q;

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Directed bench for lfsr_decrypt with a behavioural dat_mem and an encryptor model.
module tb_lfsr_decrypt;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic [7:0] data_out, raddr, waddr, data_in;
    logic       write_en, done, fail;
    logic [2:0] taps_sel;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic [7:0] pt  [64];
    logic       load = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;

    lfsr_decrypt dut (
        .clk      (clk),
        .init     (init),
        .data_out (data_out),
        .raddr    (raddr),
        .waddr    (waddr),
        .data_in  (data_in),
        .write_en (write_en),
        .done     (done),
        .fail     (fail),
        .taps_sel (taps_sel)
    );

    always #5 clk = ~clk;

    assign data_out = mem[raddr];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (write_en) begin
            mem[waddr] <= data_in;
        end
    end

    always @(negedge clk) if (write_en) wr_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
        return {s[4:0], ^(s & t)};
    endfunction

    task automatic set_pt(input int pre_len, input string msg, input logic [7:0] fill);
        for (int i = 0; i < 64; i++) begin
            if (i < pre_len) pt[i] = 8'h5F;
            else if (i - pre_len < msg.len()) pt[i] = msg[i - pre_len];
            else pt[i] = fill;
        end
    endtask

    task automatic scramble(input logic [5:0] taps, input logic [5:0] start);
        logic [5:0] s;
        s = start;
        for (int i = 0; i < 256; i++) img[i] = 8'hAA;
        for (int i = 0; i < 64; i++) begin
            img[64 + i] = pt[i] ^ {2'b00, s};
            s = step(s, taps);
        end
    endtask

    task automatic load_mem();
        init = 1'b1;
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        @(negedge clk) init = 1'b0;
        for (int c = 0; c < 400 && !done; c++) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_str(input string tag, input int base, input string exp);
        for (int i = 0; i < exp.len(); i++)
            check($sformatf("%s_mem%0d", tag, base + i), 32'(mem[base + i]), 32'(exp[i]));
    endtask

    initial begin
        int wr0;

        #1;
        check("rst_done",  32'(done),     32'd0);
        check("rst_fail",  32'(fail),     32'd0);
        check("rst_sel",   32'(taps_sel), 32'd0);
        check("rst_we",    32'(write_en), 32'd0);
        check("rst_raddr", 32'(raddr),    32'd0);
        check("rst_waddr", 32'(waddr),    32'd0);

        // First candidate, 10-byte preamble
        set_pt(10, "Hello", 8'h5F);
        scramble(6'h21, 6'h01);
        check("t1_frame0", 32'(img[64]), 32'h5E);
        load_mem();
        run_to_done("t1");
        check("t1_fail", 32'(fail), 32'd0);
        check("t1_sel",  32'(taps_sel), 32'd0);
        check_str("t1", 0, "Hello");

        // Last candidate, preamble exactly CHECK_LEN
        for (int i = 0; i < 64; i++) pt[i] = (i < 8) ? 8'h5F : 8'(8'h41 + (i % 26));
        scramble(6'h39, 6'h3F);
        load_mem();
        run_to_done("t2");
        check("t2_fail", 32'(fail), 32'd0);
        check("t2_sel",  32'(taps_sel), 32'd5);
        for (int i = 8; i < 64; i++)
            check($sformatf("t2_mem%0d", i - 8), 32'(mem[i - 8]), 32'(8'h41 + (i % 26)));

        // Garbage frame: bit 7 set everywhere so no candidate can match
        for (int i = 0; i < 256; i++) img[i] = 8'hAA;
        for (int i = 0; i < 64; i++) img[64 + i] = 8'($urandom_range(0, 255)) | 8'h80;
        load_mem();
        wr0 = wr_cnt;
        run_to_done("t3");
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_writes", 32'(wr_cnt - wr0), 32'd0);
        check("t3_mem0", 32'(mem[0]), 32'hAA);

        // Embedded '_' in the message is kept
        set_pt(12, "a_b", 8'h7A);
        scramble(6'h21, 6'h2A);
        load_mem();
        run_to_done("t4");
        check("t4_fail", 32'(fail), 32'd0);
        check("t4_sel",  32'(taps_sel), 32'd0);
        check("t4_mem0", 32'(mem[0]), 32'h61);
        check("t4_mem1", 32'(mem[1]), 32'h5F);
        check("t4_mem2", 32'(mem[2]), 32'h62);

        // Abort during RUN, then full rerun without reloading memory
        set_pt(10, "Hello", 8'h5F);
        scramble(6'h21, 6'h01);
        load_mem();
        @(negedge clk) init = 1'b0;
        repeat (29) @(negedge clk);
        check("t5_we_before", 32'(write_en), 32'd1);
        init = 1'b1;
        #1;
        check("t5_we_abort",   32'(write_en), 32'd0);
        check("t5_done_abort", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        run_to_done("t5");
        check("t5_fail", 32'(fail), 32'd0);
        check_str("t5", 0, "Hello");

        // Message at the very end of the frame: padding behaviour
        set_pt(59, "World", 8'h5F);
        scramble(6'h21, 6'h07);
        load_mem();
        run_to_done("t6");
        check("t6_fail", 32'(fail), 32'd0);
        check_str("t6", 0, "World");
`ifdef DECRYPT_PAD_EN
        for (int i = 5; i < 64; i++)
            check($sformatf("t6_pad%0d", i), 32'(mem[i]), 32'h20);
`else
        check("t6_mem5", 32'(mem[5]), 32'hAA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
